// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one imem request at a time for the current PC
// and holds the returned word in a decode-facing output register.
module fetch_unit #(
  parameter logic [31:0] NOP = 32'h00000000
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_cnt
);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] req_pc;
  logic        grant;
  logic        load;
  logic        accept;

  assign imem_addr = pc;

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    grant    = 1'b0;
    load     = 1'b0;
    accept   = ins_valid && ins_ready;
    // A request only goes out when the output register is free this cycle.
    case (state)
      FETCH: begin
        imem_req = !flush && (!ins_valid || ins_ready);
        grant    = imem_req && imem_gnt;
        if (grant) state_nx = WAIT;
      end
      WAIT: begin
        load = imem_rvalid && !flush;
        if (imem_rvalid)  state_nx = FETCH;
        else if (flush)   state_nx = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) state_nx = FETCH;
      end
      default: state_nx = FETCH;
    endcase
    pc_hold = !flush && !grant;
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) state <= FETCH;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      req_pc    <= '0;
      ins       <= NOP;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
      ins_cnt   <= '0;
    end else begin
      if (grant) req_pc <= pc;
      // Flush beats load beats accept-clear; counting is independent of all three.
      if (flush) begin
        ins_valid <= 1'b0;
        ins       <= NOP;
      end else if (load) begin
        ins_valid <= 1'b1;
        ins       <= imem_rdata;
        ins_pc    <= req_pc;
      end else if (accept) begin
        ins_valid <= 1'b0;
      end
      if (accept) ins_cnt <= ins_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: transaction-level model compared every cycle,
// plus hand-computed literal expectations at key points.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        rstd;
  logic [31:0] pc;
  logic        flush;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_cnt;

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(.NOP(NOP)) dut (
    .clk(clk), .rstd(rstd), .pc(pc), .flush(flush), .pc_hold(pc_hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ins(ins),
    .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_cnt(ins_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
  endtask

  // Transaction model: one outstanding fetch (m_out), whether its response is
  // to be thrown away (m_drop), and a one-deep instruction buffer.
  logic        m_init = 1'b0;
  logic        m_out, m_drop, m_vld;
  logic [31:0] m_opc, m_ins, m_ipc, m_cnt;
  logic [31:0] cnt_bias = '0;
  logic        e_req, e_hold, e_grant, m_load, m_acc;

  assign e_req   = !m_out && !flush && (!m_vld || ins_ready);
  assign e_grant = e_req && imem_gnt;
  assign e_hold  = !flush && !e_grant;
  assign m_load  = m_out && imem_rvalid && !m_drop && !flush;
  assign m_acc   = m_vld && ins_ready;

  always @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      m_init <= 1'b1;
      m_out  <= 1'b0;
      m_drop <= 1'b0;
      m_vld  <= 1'b0;
      m_opc  <= '0;
      m_ins  <= NOP;
      m_ipc  <= '0;
      m_cnt  <= '0;
    end else begin
      if (m_acc) m_cnt <= m_cnt + 32'd1;
      if (m_out && imem_rvalid) begin
        m_out  <= 1'b0;
        m_drop <= 1'b0;
      end else if (m_out && flush) begin
        m_drop <= 1'b1;
      end
      if (e_grant) begin
        m_out  <= 1'b1;
        m_drop <= 1'b0;
        m_opc  <= pc;
      end
      if (flush) begin
        m_vld <= 1'b0;
        m_ins <= NOP;
      end else if (m_load) begin
        m_vld <= 1'b1;
        m_ins <= imem_rdata;
        m_ipc <= m_opc;
      end else if (m_acc) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_req",  {31'd0, imem_req},  {31'd0, e_req});
      chk("pc_hold",   {31'd0, pc_hold},   {31'd0, e_hold});
      chk("imem_addr", imem_addr,          pc);
      chk("ins_valid", {31'd0, ins_valid}, {31'd0, m_vld});
      chk("ins",       ins,                m_ins);
      chk("ins_pc",    ins_pc,             m_ipc);
      chk("ins_cnt",   ins_cnt,            m_cnt + cnt_bias);
    end
  end

  task automatic drive(input logic [31:0] p, input logic f, input logic g,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    pc = p; flush = f; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; ins_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstd = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    #10 rstd = 1'b0;
    #2;
    chk("rst ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst ins", ins, NOP);
    chk("rst ins_pc", ins_pc, 32'd0);
    chk("rst ins_cnt", ins_cnt, 32'd0);
    #14;
    // first fetch at pc 0
    drive(32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    #4 rstd = 1'b1;
    #2;
    chk("first req", {31'd0, imem_req}, 32'd1);
    chk("first pc_hold", {31'd0, pc_hold}, 32'd0);
    @(posedge clk); #1;
    drive(32'd4, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1);
    #1 chk("wait req", {31'd0, imem_req}, 32'd0);
    step();
    chk("first ins", ins, 32'h12345678);
    chk("first ins_pc", ins_pc, 32'd0);
    chk("first ins_valid", {31'd0, ins_valid}, 32'd1);
    // streaming pcs 4, 8, 12
    for (int i = 1; i <= 3; i++) begin
      drive(32'(4 * i), 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
      step();
      drive(32'(4 * i + 4), 1'b0, 1'b1, 1'b1, 32'h11110000 + 32'(4 * i), 1'b1);
      step();
      chk("stream ins_pc", ins_pc, 32'(4 * i));
    end
    chk("stream ins", ins, 32'h1111000c);
    chk("stream cnt before bp", ins_cnt, 32'd3);
    // backpressure
    for (int i = 0; i < 3; i++) begin
      drive(32'd16, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      #1;
      chk("bp req", {31'd0, imem_req}, 32'd0);
      chk("bp pc_hold", {31'd0, pc_hold}, 32'd1);
      chk("bp ins", ins, 32'h1111000c);
      step();
    end
    drive(32'd16, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    #1 chk("bp release req", {31'd0, imem_req}, 32'd1);
    step();
    chk("stream cnt", ins_cnt, 32'd4);
    drive(32'd20, 1'b0, 1'b1, 1'b1, 32'h11110010, 1'b1);
    step();
    // grant stall
    for (int i = 0; i < 2; i++) begin
      drive(32'd20, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      #1;
      chk("stall pc_hold", {31'd0, pc_hold}, 32'd1);
      chk("stall addr", imem_addr, 32'd20);
      step();
    end
    drive(32'd20, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    #1 chk("stall grant pc_hold", {31'd0, pc_hold}, 32'd0);
    step();
    // flush while waiting, stale response dropped
    drive(32'd24, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step();
    chk("flush ins", ins, NOP);
    chk("flush ins_valid", {31'd0, ins_valid}, 32'd0);
    drive(32'd100, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    #1 chk("drain req", {31'd0, imem_req}, 32'd0);
    step();
    drive(32'd100, 1'b0, 1'b1, 1'b1, 32'hdeadbeef, 1'b1);
    step();
    chk("drain ins", ins, NOP);
    chk("drain ins_valid", {31'd0, ins_valid}, 32'd0);
    drive(32'd100, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    #1;
    chk("redirect req", {31'd0, imem_req}, 32'd1);
    chk("redirect addr", imem_addr, 32'd100);
    step();
    drive(32'd104, 1'b0, 1'b1, 1'b1, 32'h11110100, 1'b0);
    step();
    chk("redirect ins_pc", ins_pc, 32'd100);
    chk("redirect ins", ins, 32'h11110100);
    // counter wrap
    force dut.ins_cnt = 32'hffffffff;
    cnt_bias = 32'hffffffff - m_cnt;
    #1 release dut.ins_cnt;
    drive(32'd104, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step();
    chk("wrap cnt", ins_cnt, 32'd0);
    drive(32'd104, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step();
    // async reset mid-WAIT
    drive(32'd108, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    #2;
    rstd = 1'b0;
    cnt_bias = '0;
    #1;
    chk("async ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("async ins", ins, NOP);
    chk("async ins_pc", ins_pc, 32'd0);
    chk("async ins_cnt", ins_cnt, 32'd0);
    chk("async req", {31'd0, imem_req}, 32'd1);
    chk("async pc_hold", {31'd0, pc_hold}, 32'd1);
    step();
    #2 rstd = 1'b1;
    @(posedge clk); #1;
    drive(32'd0, 1'b0, 1'b0, 1'b1, 32'hdeadbeef, 1'b1);
    step();
    chk("stale ins_valid", {31'd0, ins_valid}, 32'd0);
    chk("stale ins", ins, NOP);
    drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
